// File: rtl/fib_pwm_pkg.sv
// Shared types and elaboration helpers for the Fibonacci breathing PWM.
// No logic: enums for the channel FSM/direction and a constant Fibonacci function.
package fib_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // F(1)=F(2)=1; used only at elaboration to size-check the counters.
  function automatic longint unsigned fib(input int n);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    a = 0;
    b = 1;
    for (int i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

endpackage

// File: rtl/fib_pwm_channel.sv
// One breathing PWM channel: HIGH pulses of Fibonacci width separated by a LOW gap.
// All outputs registered (1-cycle from en); no backpressure, free-running while enabled.
module fib_pwm_channel
  import fib_pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MAX_IDX = 10,
  parameter int IDX_W   = $clog2(MAX_IDX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             pwm_out,
  output logic             breath_done,
  output logic [IDX_W-1:0] fib_idx
);

  state_t           state;
  dir_t             dir;
  logic [CNT_W-1:0] fib_a;
  logic [CNT_W-1:0] fib_b;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] nxt_a;
  logic [CNT_W-1:0] nxt_b;
  logic [IDX_W-1:0] nxt_k;
  dir_t             nxt_dir;
  logic             nxt_done;
  logic [CNT_W-1:0] gap_m1;

  assign gap_m1 = (low_cycles == '0) ? '0 : low_cycles - CNT_W'(1);

  // Index step taken on LOW exit, including both turnarounds.
  always_comb begin
    nxt_a    = fib_a;
    nxt_b    = fib_b;
    nxt_k    = fib_idx;
    nxt_dir  = dir;
    nxt_done = 1'b0;
    if (dir == DIR_UP) begin
      if (fib_idx == IDX_W'(MAX_IDX)) begin
        if (!mode) begin
          nxt_a    = '0;
          nxt_b    = CNT_W'(1);
          nxt_k    = IDX_W'(1);
          nxt_done = 1'b1;
        end else begin
          nxt_dir = DIR_DOWN;
          nxt_a   = fib_b - fib_a;
          nxt_b   = fib_a;
          nxt_k   = fib_idx - IDX_W'(1);
        end
      end else begin
        nxt_a = fib_b;
        nxt_b = fib_a + fib_b;
        nxt_k = fib_idx + IDX_W'(1);
      end
    end else begin
      if (fib_idx == IDX_W'(1)) begin
        nxt_done = 1'b1;
        nxt_dir  = DIR_UP;
        nxt_a    = fib_b;
        nxt_b    = fib_a + fib_b;
        nxt_k    = fib_idx + IDX_W'(1);
      end else begin
        nxt_a = fib_b - fib_a;
        nxt_b = fib_a;
        nxt_k = fib_idx - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dir         <= DIR_UP;
      fib_a       <= '0;
      fib_b       <= CNT_W'(1);
      cnt         <= '0;
      fib_idx     <= IDX_W'(1);
      pwm_out     <= 1'b0;
      breath_done <= 1'b0;
    end else begin
      breath_done <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        dir     <= DIR_UP;
        fib_a   <= '0;
        fib_b   <= CNT_W'(1);
        cnt     <= '0;
        fib_idx <= IDX_W'(1);
        pwm_out <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_HIGH;
            pwm_out <= 1'b1;
            cnt     <= fib_b - CNT_W'(1);
          end
          ST_HIGH: begin
            if (cnt == '0) begin
              state   <= ST_LOW;
              pwm_out <= 1'b0;
              cnt     <= gap_m1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_LOW: begin
            if (cnt == '0) begin
              state       <= ST_HIGH;
              pwm_out     <= 1'b1;
              fib_a       <= nxt_a;
              fib_b       <= nxt_b;
              fib_idx     <= nxt_k;
              dir         <= nxt_dir;
              breath_done <= nxt_done;
              cnt         <= nxt_b - CNT_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            pwm_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/fib_breathing_pwm_multi.sv
// NUM_CH independent Fibonacci breathing PWM channels sharing mode and gap length.
// Outputs registered per channel; no backpressure, fib_idx packed with channel 0 in LSBs.
module fib_breathing_pwm_multi
  import fib_pwm_pkg::*;
#(
  parameter int   NUM_CH  = 4,
  parameter int   CNT_W   = 16,
  parameter int   MAX_IDX = 10,
  localparam int  IDX_W   = $clog2(MAX_IDX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    mode,
  input  logic [CNT_W-1:0]        low_cycles,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       breath_done,
  output logic [NUM_CH*IDX_W-1:0] fib_idx
);

  // The widest pulse must fit in the pair registers and counter.
  if ((fib(MAX_IDX) >> CNT_W) != 0) begin : g_width_chk
    $error("F(MAX_IDX) does not fit in CNT_W bits");
  end
  if (MAX_IDX < 3) begin : g_idx_chk
    $error("MAX_IDX must be at least 3");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fib_pwm_channel #(
      .CNT_W   (CNT_W),
      .MAX_IDX (MAX_IDX),
      .IDX_W   (IDX_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (en[i]),
      .mode        (mode),
      .low_cycles  (low_cycles),
      .pwm_out     (pwm_out[i]),
      .breath_done (breath_done[i]),
      .fib_idx     (fib_idx[i*IDX_W +: IDX_W])
    );
  end

endmodule

// File: tb/tb_fib_breathing_pwm_multi.sv
// Bench for fib_breathing_pwm_multi: directed pulse-table runs, corner sequences, and a
// random phase, all cross-checked every cycle against a width-by-index reference model.
module tb_fib_breathing_pwm_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int MAX_IDX = 5;
  localparam int IDX_W   = 3;
  localparam int P_IDLE  = 0;
  localparam int P_HIGH  = 1;
  localparam int P_LOW   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic                    mode;
  logic [CNT_W-1:0]        low_cycles;
  logic [NUM_CH-1:0]       pwm_out;
  logic [NUM_CH-1:0]       breath_done;
  logic [NUM_CH*IDX_W-1:0] fib_idx;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fib_breathing_pwm_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .MAX_IDX (MAX_IDX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .low_cycles  (low_cycles),
    .pwm_out     (pwm_out),
    .breath_done (breath_done),
    .fib_idx     (fib_idx)
  );

  always #5 clk = ~clk;

  // Reference model: phase, cycles remaining, index k and direction; width = F(k).
  int m_ph[NUM_CH];
  int m_rem[NUM_CH];
  int m_k[NUM_CH];
  bit m_down[NUM_CH];
  bit m_pwm[NUM_CH];
  bit m_done[NUM_CH];

  function automatic int fibf(input int n);
    int a = 0;
    int b = 1;
    int t;
    for (int j = 1; j < n; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  task automatic model_idle(input int i);
    m_ph[i] = P_IDLE; m_rem[i] = 0; m_k[i] = 1; m_down[i] = 0; m_pwm[i] = 0;
  endtask

  task automatic model_advance(input int i);
    if (!m_down[i]) begin
      if (m_k[i] == MAX_IDX) begin
        if (!mode) begin
          m_k[i] = 1; m_done[i] = 1;
        end else begin
          m_down[i] = 1; m_k[i] = m_k[i] - 1;
        end
      end else begin
        m_k[i] = m_k[i] + 1;
      end
    end else if (m_k[i] == 1) begin
      m_done[i] = 1; m_down[i] = 0; m_k[i] = 2;
    end else begin
      m_k[i] = m_k[i] - 1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      m_done[i] = 0;
      if (rst || !en[i]) begin
        model_idle(i);
      end else begin
        case (m_ph[i])
          P_IDLE: begin m_ph[i] = P_HIGH; m_rem[i] = fibf(m_k[i]); m_pwm[i] = 1; end
          P_HIGH: begin
            if (m_rem[i] == 1) begin
              m_ph[i] = P_LOW; m_pwm[i] = 0;
              m_rem[i] = (low_cycles == 0) ? 1 : int'(low_cycles);
            end else m_rem[i] = m_rem[i] - 1;
          end
          default: begin
            if (m_rem[i] == 1) begin
              model_advance(i);
              m_ph[i] = P_HIGH; m_rem[i] = fibf(m_k[i]); m_pwm[i] = 1;
            end else m_rem[i] = m_rem[i] - 1;
          end
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tests++;
        if (pwm_out[i] !== m_pwm[i] || breath_done[i] !== m_done[i] ||
            fib_idx[i*IDX_W +: IDX_W] !== 3'(m_k[i])) begin
          fails++;
          $display("FAIL model ch%0d @%0t: got pwm=%b done=%b idx=%0d, expected pwm=%b done=%b idx=%0d",
                   i, $time, pwm_out[i], breath_done[i], fib_idx[i*IDX_W +: IDX_W],
                   m_pwm[i], m_done[i], m_k[i]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge with ch0 low: counts low cycles until ch0 rises.
  task automatic wait_rise(output int lc);
    lc = 0;
    while (pwm_out[0] !== 1'b1 && lc < 200) begin
      lc++;
      @(negedge clk);
    end
    check("ch0 rise within bound", int'(pwm_out[0] === 1'b1), 1);
  endtask

  task automatic measure_high(output int w);
    w = 0;
    while (pwm_out[0] === 1'b1 && w < 200) begin
      w++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit restart;
    bit md;
    int low;
    int width;
    int idx;
    bit done;
    int gap;
  } vec_t;

  vec_t tbl[$];
  int   tri_w[14] = '{1, 1, 2, 3, 5, 3, 2, 1, 1, 1, 2, 3, 5, 3};
  int   tri_k[14] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 2, 3, 4, 5, 4};
  int   saw_w[8]  = '{1, 1, 2, 3, 5, 1, 1, 2};
  int   saw_k[8]  = '{1, 2, 3, 4, 5, 1, 2, 3};
  int   post_w[3] = '{1, 1, 2};

  initial begin
    int   lc;
    int   w;
    bit   seen5;
    bit   desc;
    bit   got_done;
    vec_t v;

    for (int j = 0; j < 14; j++)
      tbl.push_back('{restart: (j == 0), md: 1'b1, low: 2, width: tri_w[j], idx: tri_k[j],
                      done: (j == 9), gap: (j == 0) ? 0 : 2});
    for (int j = 0; j < 8; j++)
      tbl.push_back('{restart: (j == 0), md: 1'b0, low: 3, width: saw_w[j], idx: saw_k[j],
                      done: (j == 5), gap: (j == 0) ? 0 : 3});
    for (int j = 0; j < 4; j++)
      tbl.push_back('{restart: (j == 0), md: 1'b0, low: 0, width: saw_w[j], idx: saw_k[j],
                      done: 1'b0, gap: (j == 0) ? 0 : 1});

    rst = 1'b0; en = '0; mode = 1'b0; low_cycles = '0;
    #1 rst = 1'b1;
    #1;
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset breath_done", int'(breath_done), 0);
    check("reset fib_idx", int'(fib_idx), 'h249);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      mode = v.md;
      low_cycles = CNT_W'(v.low);
      if (v.restart) begin
        en[0] = 1'b0;
        repeat (2) @(negedge clk);
        en[0] = 1'b1;
      end
      wait_rise(lc);
      check($sformatf("row%0d breath_done", r), int'(breath_done[0]), int'(v.done));
      check($sformatf("row%0d fib_idx", r), int'(fib_idx[IDX_W-1:0]), v.idx);
      measure_high(w);
      check($sformatf("row%0d width", r), w, v.width);
      if (v.gap != 0) check($sformatf("row%0d gap", r), lc, v.gap);
    end

    // Gap length is sampled on LOW entry, so a mid-pulse change applies to this pulse.
    wait_rise(lc);
    check("zero-low gap", lc, 1);
    check("pre-change idx", int'(fib_idx[IDX_W-1:0]), 5);
    @(negedge clk);
    low_cycles = CNT_W'(4);
    measure_high(w);
    check("remaining width after low change", w, 4);
    wait_rise(lc);
    check("gap after mid-high change", lc, 4);
    check("sawtooth reload idx", int'(fib_idx[IDX_W-1:0]), 1);
    check("sawtooth reload done", int'(breath_done[0]), 1);

    // Disable during cycle 2 of the 5-wide pulse.
    low_cycles = CNT_W'(1);
    measure_high(w);
    for (int p = 0; p < 10; p++) begin
      wait_rise(lc);
      if (fib_idx[IDX_W-1:0] == 3'd5) break;
      measure_high(w);
    end
    check("reach 5-wide pulse", int'(fib_idx[IDX_W-1:0]), 5);
    @(negedge clk);
    check("still high in cycle 2", int'(pwm_out[0]), 1);
    en[0] = 1'b0;
    @(negedge clk);
    check("disable pwm low", int'(pwm_out[0]), 0);
    check("disable idx", int'(fib_idx[IDX_W-1:0]), 1);
    en[0] = 1'b1;
    @(negedge clk);
    measure_high(w);
    check("re-enable width", w, 1);

    // Asynchronous reset in the middle of a HIGH pulse.
    for (int p = 0; p < 10; p++) begin
      wait_rise(lc);
      if (fib_idx[IDX_W-1:0] == 3'd3) break;
      measure_high(w);
    end
    check("reach 2-wide pulse", int'(fib_idx[IDX_W-1:0]), 3);
    #2 rst = 1'b1;
    #1;
    check("async rst pwm_out", int'(pwm_out), 0);
    check("async rst breath_done", int'(breath_done), 0);
    check("async rst fib_idx", int'(fib_idx), 'h249);
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wait_rise(lc);
      measure_high(w);
      check($sformatf("post-reset pulse%0d width", p), w, post_w[p]);
    end

    // Independent channels; mode drop during descent must not cut the breath short.
    en = '0; mode = 1'b1; low_cycles = CNT_W'(2);
    repeat (2) @(negedge clk);
    en = 4'b0001;
    repeat (20) @(negedge clk);
    en[2] = 1'b1;
    seen5 = 1'b0;
    desc = 1'b0;
    for (int c = 0; c < 300 && !desc; c++) begin
      @(negedge clk);
      if (fib_idx[IDX_W-1:0] == 3'd5) seen5 = 1'b1;
      else if (seen5 && fib_idx[IDX_W-1:0] == 3'd4) desc = 1'b1;
    end
    check("ch0 descending", int'(desc), 1);
    mode = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clk);
      if (breath_done[0] === 1'b1) got_done = 1'b1;
    end
    check("ch0 descent completes", int'(got_done), 1);
    check("ch0 idx after bottom", int'(fib_idx[IDX_W-1:0]), 2);
    check("ch1 idle", int'(pwm_out[1]), 0);
    check("ch3 idle", int'(pwm_out[3]), 0);
    check("ch2 running idx", int'(fib_idx[2*IDX_W +: IDX_W] != 3'd0), 1);

    // Random phase, checked only by the per-cycle model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) en[$urandom_range(NUM_CH-1)] ^= 1'b1;
      if ($urandom_range(99) == 0) mode = 1'($urandom_range(1));
      if ($urandom_range(49) == 0) low_cycles = CNT_W'($urandom_range(4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
